acc_share_ctrl: RTL

//   Round-robin scheduler that shares one WIDTH-bit serial-bit accumulator among NREQ requesters.

---
 rtl/acc_ctrl_pkg.sv | 45 ++++
 rtl/acc_core.sv | 75 +++++++
 rtl/acc_share_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/acc_ctrl_pkg.sv
// ============================================================================
// Package : acc_ctrl_pkg
// Shared state encoding and round-robin helpers for acc_share_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

package acc_ctrl_pkg;

    localparam int MAX_NREQ = 32;
    localparam int MAX_ID_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_e;

    // First requester at or after last_id+1 (mod nreq) with req set.
    function automatic int unsigned rr_pick(input logic [MAX_NREQ-1:0] req,
                                            input int unsigned last_id,
                                            input int unsigned nreq);
        int unsigned idx;
        logic        found;
        rr_pick = 0;
        found   = 1'b0;
        for (int unsigned i = 1; i <= MAX_NREQ; i++) begin
            if (i <= nreq) begin
                idx = (last_id + i) % nreq;
                if (!found && req[idx[MAX_ID_W-1:0]]) begin
                    rr_pick = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

    function automatic logic [MAX_NREQ-1:0] onehot(input int unsigned id);
        onehot = '0;
        onehot[id[MAX_ID_W-1:0]] = 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/acc_core.sv
// ============================================================================
// Module  : acc_core
// WIDTH-bit serial-bit accumulator with sync clear; saturates when ACC_SAT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module acc_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] acc_q, acc_d;

`ifdef ACC_SAT_EN
    logic ovf_q, ovf_d;

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (en_i && bit_i) begin
            if (&acc_q) begin
                ovf_d = 1'b1;
            end else begin
                acc_d = acc_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`else
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i && bit_i) begin
            acc_d = acc_q + WIDTH'(1);
        end
    end

    assign ovf_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Next-state value lets the controller capture the final sum on the last window edge.
    assign sum_o = acc_d;

endmodule

`default_nettype wire

// File: rtl/acc_share_ctrl.sv
// ============================================================================
// Module  : acc_share_ctrl
// Round-robin sharing of one serial-bit accumulator; optional ACC_SAT_EN saturation.
// Revision: 1.0
// ============================================================================
`default_nettype none

module acc_share_ctrl
    import acc_ctrl_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int LEN_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         bit_in,
    input  logic [LEN_W-1:0]        len,
    output logic [NREQ-1:0]         grant,
    output logic                    busy,
    output logic [WIDTH-1:0]        result,
    output logic [$clog2(NREQ)-1:0] result_id,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic                    overflow
);

    localparam int ID_W = $clog2(NREQ);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]  last_id_q, last_id_d;
    logic [ID_W-1:0]  result_id_q, result_id_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;

    logic             acc_clr;
    logic             acc_en;
    logic             acc_bit;
    logic [WIDTH-1:0] acc_sum;
    logic             acc_ovf;
    int unsigned      winner;

    acc_core #(
        .WIDTH (WIDTH)
    ) u_acc_core (
        .clk   (clk),
        .rst   (rst),
        .clr_i (acc_clr),
        .en_i  (acc_en),
        .bit_i (acc_bit),
        .sum_o (acc_sum),
        .ovf_o (acc_ovf)
    );

    assign winner  = rr_pick(MAX_NREQ'(req), 32'(last_id_q), NREQ);
    assign acc_bit = bit_in[result_id_q];

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        last_id_d      = last_id_q;
        result_id_d    = result_id_q;
        grant_d        = grant_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        acc_clr        = 1'b0;
        acc_en         = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    result_id_d = ID_W'(winner);
                    grant_d     = NREQ'(onehot(winner));
                    cnt_d       = len;
                    acc_clr     = 1'b1;
                    if (len != '0) begin
                        state_d = ACCUM;
                    end else begin
                        // Empty window: report zero right away, grant lasts a single cycle.
                        result_d       = '0;
                        result_valid_d = 1'b1;
                        state_d        = REPORT;
                    end
                end
            end
            ACCUM: begin
                acc_en = 1'b1;
                cnt_d  = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    result_d       = acc_sum;
                    result_valid_d = 1'b1;
                    grant_d        = '0;
                    state_d        = REPORT;
                end
            end
            REPORT: begin
                grant_d = '0;
                if (result_valid_q && result_ready) begin
                    result_valid_d = 1'b0;
                    last_id_d      = result_id_q;
                    state_d        = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            last_id_q      <= ID_W'(NREQ - 1);
            result_id_q    <= '0;
            grant_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            last_id_q      <= last_id_d;
            result_id_q    <= result_id_d;
            grant_q        <= grant_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign grant        = grant_q;
    assign busy         = (state_q != IDLE);
    assign result       = result_q;
    assign result_id    = result_id_q;
    assign result_valid = result_valid_q;
    assign overflow     = acc_ovf;

endmodule

`default_nettype wire
